// File: rtl/cache_pkg.sv
// Shared cache constants: block geometry and fill FSM state encoding.
// The tag/index logic elsewhere in the cache also uses these constants.
package cache_pkg;

  localparam int BLOCK_BYTES     = 16;
  localparam int WORDS_PER_BLOCK = 8;
  localparam int OFFSET_BITS     = 4;
  localparam int WORD_IDX_BITS   = 3;
  // One extra bit so a word counter can hold WORDS_PER_BLOCK itself.
  localparam int CNT_BITS        = WORD_IDX_BITS + 1;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } fill_state_t;

  // Byte offset of a 16-bit word within its block.
  function automatic logic [OFFSET_BITS-1:0] word_byte_off(input logic [WORD_IDX_BITS-1:0] idx);
    return {idx, 1'b0};
  endfunction

endpackage

// File: rtl/cache_fill_fsm_if.sv
// Miss / memory / data-array signals of one cache fill engine.
// master = the fill engine, slave = the cache and memory around it.
interface cache_fill_fsm_if #(
  parameter int ADDR_WIDTH = 16
);
  logic                  miss_detected;
  logic [ADDR_WIDTH-1:0] miss_address;
  logic                  memory_data_valid;
  logic [15:0]           memory_data;
  logic                  fsm_busy;
  logic                  memory_enable;
  logic [ADDR_WIDTH-1:0] memory_address;
  logic                  write_data_array;
  logic [2:0]            data_word_offset;
  logic [15:0]           cache_write_data;
  logic                  write_tag_array;
  logic                  fill_done;

  modport master (
    input  miss_detected, miss_address, memory_data_valid, memory_data,
    output fsm_busy, memory_enable, memory_address, write_data_array,
           data_word_offset, cache_write_data, write_tag_array, fill_done
  );

  modport slave (
    output miss_detected, miss_address, memory_data_valid, memory_data,
    input  fsm_busy, memory_enable, memory_address, write_data_array,
           data_word_offset, cache_write_data, write_tag_array, fill_done
  );
endinterface

// File: rtl/dff.sv
// Generic register cell with synchronous active-high reset to zero.
// Latency: one cycle from d to q.
// No flow control.
module dff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Capture d every edge; reset forces zero.
  always_ff @(posedge clk) begin
    if (rst) q <= '0;
    else     q <= d;
  end

endmodule

// File: rtl/fill_word_counter.sv
// Word counter for a block fill: synchronous clear, increment enable,
// saturates at WORDS_PER_BLOCK so it can never wrap into a new block.
// Latency: count visible the cycle after the enabling edge.
module fill_word_counter
  import cache_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                inc,
  output logic [CNT_BITS-1:0] cnt_q
);

  logic [CNT_BITS-1:0] cnt_d;

  // Clear wins over increment; hold once the full block has been counted.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != CNT_BITS'(WORDS_PER_BLOCK))) begin
      cnt_d = cnt_q + CNT_BITS'(1);
    end
  end

  dff #(.W(CNT_BITS)) u_cnt (
    .clk (clk),
    .rst (rst),
    .d   (cnt_d),
    .q   (cnt_q)
  );

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss fill engine: streams one 16-byte block from pipelined memory
// into the data array, word by word, then writes the tag.
// Requests in the 8 cycles after acceptance; last write + tag + fill_done
// MEM_LATENCY cycles after the last request. No backpressure: memory
// returns one word per valid and the cache is stalled via fsm_busy.
module cache_fill_fsm
  import cache_pkg::*;
#(
  parameter int ADDR_WIDTH      = 16,
  parameter int WORDS_PER_BLOCK = 8,
  parameter int MEM_LATENCY     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  cache_fill_fsm_if.master      bus
);

  // The datapath is built around the package block geometry; reject
  // parameterisations that disagree with it.
  generate
    if ((WORDS_PER_BLOCK != cache_pkg::WORDS_PER_BLOCK) || (MEM_LATENCY < 1) ||
        (ADDR_WIDTH <= OFFSET_BITS)) begin : g_bad_cfg
      $error("cache_fill_fsm: unsupported parameter combination");
    end
  endgenerate

  localparam logic [ADDR_WIDTH-1:0] BLOCK_MASK = ~ADDR_WIDTH'(BLOCK_BYTES - 1);
  localparam logic [CNT_BITS-1:0]   LAST_IDX   = CNT_BITS'(cache_pkg::WORDS_PER_BLOCK - 1);
  localparam logic [CNT_BITS-1:0]   FULL_CNT   = CNT_BITS'(cache_pkg::WORDS_PER_BLOCK);

  fill_state_t           state_q, state_d;
  logic                  state_bit_q;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [CNT_BITS-1:0]   issue_cnt, recv_cnt;
  logic                  cnt_clr, issue_inc, recv_inc;

  assign state_q = fill_state_t'(state_bit_q);

  // Next state, counter control and all outputs; everything is forced to
  // zero while rst is high so the pipeline sees a quiet engine in reset.
  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    cnt_clr   = 1'b0;
    issue_inc = 1'b0;
    recv_inc  = 1'b0;

    bus.fsm_busy         = 1'b0;
    bus.memory_enable    = 1'b0;
    bus.memory_address   = '0;
    bus.write_data_array = 1'b0;
    bus.data_word_offset = '0;
    bus.write_tag_array  = 1'b0;
    bus.fill_done        = 1'b0;

    if (!rst) begin
      case (state_q)
        IDLE: begin
          // Returned data is ignored here; only a miss starts a fill.
          if (bus.miss_detected) begin
            base_d       = bus.miss_address & BLOCK_MASK;
            cnt_clr      = 1'b1;
            bus.fsm_busy = 1'b1;
            state_d      = FILL;
          end
        end
        FILL: begin
          bus.fsm_busy = 1'b1;

          // Issue side: one request per cycle until the block is covered.
          // base is block-aligned so the add never carries out of the block.
          if (issue_cnt < FULL_CNT) begin
            bus.memory_enable  = 1'b1;
            bus.memory_address = base_q |
                                 ADDR_WIDTH'(word_byte_off(issue_cnt[WORD_IDX_BITS-1:0]));
            issue_inc          = 1'b1;
          end

          // Receive side: steer each returned word to its slot.
          bus.write_data_array = bus.memory_data_valid;
          bus.data_word_offset = recv_cnt[WORD_IDX_BITS-1:0];
          recv_inc             = bus.memory_data_valid;

          // Last word lands: tag write and completion in the same cycle.
          if (bus.memory_data_valid && (recv_cnt == LAST_IDX)) begin
            bus.write_tag_array = 1'b1;
            bus.fill_done       = 1'b1;
            state_d             = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Data array write data is a straight pass-through of the memory bus.
  assign bus.cache_write_data = bus.memory_data;

  dff #(.W(1)) u_state (
    .clk (clk),
    .rst (rst),
    .d   (state_d),
    .q   (state_bit_q)
  );

  dff #(.W(ADDR_WIDTH)) u_base (
    .clk (clk),
    .rst (rst),
    .d   (base_d),
    .q   (base_q)
  );

  fill_word_counter u_issue_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .inc   (issue_inc),
    .cnt_q (issue_cnt)
  );

  fill_word_counter u_recv_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .inc   (recv_inc),
    .cnt_q (recv_cnt)
  );

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Scoreboard bench for cache_fill_fsm with a 4-stage pipelined memory model.
// Stimulus pushes expected requests/writes/completions with cycle stamps;
// a negedge monitor compares every cycle.
module tb_cache_fill_fsm;

  localparam int AW = 16;

  typedef struct {
    int          cyc;
    logic [15:0] a;
    logic [15:0] d;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  ev_t req_q[$];
  ev_t wr_q[$];
  ev_t done_q[$];
  int  busy_lo = 1;
  int  busy_hi = 0;

  logic        stray_vld = 1'b0;
  logic [3:0]  pv;
  logic [15:0] pd [4];

  cache_fill_fsm_if #(.ADDR_WIDTH(AW)) bus ();

  cache_fill_fsm #(.ADDR_WIDTH(AW), .WORDS_PER_BLOCK(8), .MEM_LATENCY(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Pipelined memory: a request registered at an edge returns 4 cycles on.
  always @(posedge clk) begin
    if (rst) begin
      pv <= '0;
      for (int i = 0; i < 4; i++) pd[i] <= '0;
    end else begin
      pv    <= {pv[2:0], bus.memory_enable};
      pd[0] <= 16'hA000 + {13'b0, bus.memory_address[3:1]};
      for (int i = 1; i < 4; i++) pd[i] <= pd[i-1];
    end
  end

  assign bus.memory_data_valid = pv[3] | stray_vld;
  assign bus.memory_data       = stray_vld ? 16'hDEAD : (pv[3] ? pd[3] : 16'h0000);

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // Monitor: every cycle, compare each output against the scoreboard.
  always @(negedge clk) begin
    logic exp_req, exp_wr, exp_done, exp_busy;
    exp_req  = (req_q.size()  > 0) && (req_q[0].cyc  == cyc);
    exp_wr   = (wr_q.size()   > 0) && (wr_q[0].cyc   == cyc);
    exp_done = (done_q.size() > 0) && (done_q[0].cyc == cyc);
    exp_busy = (cyc >= busy_lo) && (cyc <= busy_hi);

    chk("fsm_busy", 16'(bus.fsm_busy), 16'(exp_busy));
    chk("memory_enable", 16'(bus.memory_enable), 16'(exp_req));
    chk("write_data_array", 16'(bus.write_data_array), 16'(exp_wr));
    chk("fill_done", 16'(bus.fill_done), 16'(exp_done));
    chk("write_tag_array", 16'(bus.write_tag_array), 16'(exp_done));
    chk("cache_write_data", bus.cache_write_data, bus.memory_data);

    if (exp_req) begin
      chk("memory_address", bus.memory_address, req_q[0].a);
      void'(req_q.pop_front());
    end
    if (exp_wr) begin
      chk("data_word_offset", 16'(bus.data_word_offset), wr_q[0].a);
      chk("write_data", bus.cache_write_data, wr_q[0].d);
      void'(wr_q.pop_front());
    end
    if (exp_done) void'(done_q.pop_front());
    if (!exp_busy) begin
      chk("idle_memory_address", bus.memory_address, 16'h0000);
      chk("idle_data_word_offset", 16'(bus.data_word_offset), 16'h0000);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a miss in the current cycle T and record the expected fill.
  task automatic do_miss(input logic [15:0] a, input logic [15:0] exp_base);
    ev_t e;
    int  t;
    t = cyc;
    bus.miss_detected = 1'b1;
    bus.miss_address  = a;
    for (int i = 0; i < 8; i++) begin
      e.cyc = t + 1 + i;
      e.a   = exp_base + 16'(2 * i);
      e.d   = 16'h0000;
      req_q.push_back(e);
      e.cyc = t + 5 + i;
      e.a   = 16'(i);
      e.d   = 16'hA000 + 16'(i);
      wr_q.push_back(e);
    end
    e.cyc = t + 12;
    e.a   = 16'h0;
    e.d   = 16'h0;
    done_q.push_back(e);
    if (t != busy_hi + 1) busy_lo = t;
    busy_hi = t + 12;
  endtask

  // Step from cycle T to T+13 and release the miss there.
  task automatic finish_fill(input int already);
    for (int i = already; i < 13; i++) step();
    bus.miss_detected = 1'b0;
  endtask

  initial begin
    bus.miss_detected = 1'b0;
    bus.miss_address  = 16'h0000;

    // Reset then idle, with stray returns that must not be written.
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      stray_vld = (i >= 3 && i < 6);
      step();
    end
    stray_vld = 1'b0;

    // Single fill in the middle of the address space.
    do_miss(16'h1236, 16'h1230);
    finish_fill(0);
    step();

    // Top block: requests stay within 0xFFF0..0xFFFE.
    do_miss(16'hFFFF, 16'hFFF0);
    finish_fill(0);
    step();

    // Miss dropped at T+3: the fill still completes.
    do_miss(16'h0506, 16'h0500);
    for (int i = 0; i < 3; i++) step();
    bus.miss_detected = 1'b0;
    finish_fill(3);
    step();

    // Reset in cycle T+6 abandons the fill.
    do_miss(16'h0808, 16'h0800);
    for (int i = 0; i < 6; i++) step();
    rst = 1'b1;
    bus.miss_detected = 1'b0;
    req_q.delete();
    wr_q.delete();
    done_q.delete();
    busy_hi = cyc - 1;
    step();
    rst = 1'b0;
    step();
    step();
    do_miss(16'h0040, 16'h0040);
    finish_fill(0);
    step();

    // Back-to-back: miss held through fill_done, next block in T+13.
    do_miss(16'h2002, 16'h2000);
    for (int i = 0; i < 13; i++) step();
    do_miss(16'h301A, 16'h3010);
    finish_fill(0);

    for (int i = 0; i < 8; i++) step();

    chk("leftover_requests", 16'(req_q.size()), 16'h0);
    chk("leftover_writes", 16'(wr_q.size()), 16'h0);
    chk("leftover_done", 16'(done_q.size()), 16'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
